md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide unit in the execute stage, beside the ALU; takes the same forwarded rs/rt operands.
//  Runs MIPS mult/multu/div/divu as fixed-latency multi-cycle ops into the HI/LO registers.
//  Also handles mthi/mtlo writes. Drives Busy so the hazard unit can stall mfhi/mflo and later MD ops.
//  The arithmetic is behavioural; only latency is modelled with a countdown.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high for mult/multu (must be >= 1)
//  DIV_CYCLES   10  cycles Busy stays high for div/divu (must be >= 1)
// PORTS
//  clk     in   1   single clock; all state updates on posedge clk
//  reset   in   1   asynchronous, active-high; clears all state immediately
//  A       in   32  operand rs (dividend / multiplicand)
//  B       in   32  operand rt (divisor / multiplier)
//  MDOp    in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//  Start   out  1   comb: 1 when MDOp is 1..4 and Busy==0 (an op is accepted this cycle)
//  Busy    out  1   registered: 1 while an accepted mult/div is in progress
//  HI      out  32  registered HI register
//  LO      out  32  registered LO register
// BEHAVIOUR
//  Reset: HI=0, LO=0, Busy=0, countdown=0, pending results=0.
//   Async: takes effect without waiting for clk.
//   Reset during an op aborts it; no later HI/LO write from that op.
//  States: IDLE (Busy=0) and RUN (Busy=1). The countdown register cnt is the state.
//  IDLE, posedge with Start=1:
//   - Compute the result from A/B and latch it into pendHI/pendLO.
//   - cnt <= MULT_CYCLES or DIV_CYCLES; go to RUN.
//  RUN: cnt decrements on each posedge.
//   - On the posedge where cnt==1: HI<=pendHI, LO<=pendLO, Busy<=0.
//   - If Start occurs at posedge T, Busy=1 for exactly N cycles after T.
//   - New HI/LO are visible, with Busy=0, in cycle T+N+1.
//  Ops while Busy=1:
//   - MDOp 1..6 is ignored: no restart, no mthi/mtlo write.
//   - The hazard unit stalls on Start|Busy; this block does not queue ops.
//  mthi/mtlo: in IDLE only, HI<=A (op 5) or LO<=A (op 6) at the next posedge. One-cycle op; Busy stays 0.
//  Arithmetic:
//   - mult: {HI,LO} = $signed(A)*$signed(B) as a 64-bit result. multu: the same, unsigned.
//   - div: LO = quotient truncated toward zero; HI = remainder with the sign of A.
//   - divu: unsigned quotient and remainder.
//   - Overflow case div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  Divide by zero (B==0, op 3/4):
//   - The op runs the full DIV_CYCLES with Busy.
//   - HI/LO are left unchanged (pend regs are loaded with the current HI/LO).
//  Operands are sampled only at the Start edge. Changes on A/B during RUN have no effect.
//  Back-to-back ops:
//   - An op presented in cycle T+N+1 (Busy=0) is accepted that cycle.
//   - A stalled op presented while Busy=1 is accepted in the first cycle Busy=0.
// TESTING
//  1 mult A=0xFFFFFFFE(-2), B=3 -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
//  2 multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
//  3 div A=0xFFFFFFF9(-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
//    divu A=7, B=2 -> LO=3, HI=1.
//  4 div with B=0 after mtlo A=0x1234 -> Busy 10 cycles; HI/LO keep their old values.
//    Also: div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  5 mthi A=0xAAAA during Busy -> ignored. mult issued on cycle 2 of Busy -> ignored (Start=0).
//    mthi in IDLE -> HI=0xAAAA next cycle.
//  6 assert reset mid-div at cycle 4 -> Busy, HI, LO go to 0 immediately without a clock edge.
//    No write occurs at the old completion cycle.

Source files
------------

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Execute-stage multiply/divide unit. Runs mult/multu/div/divu
//               as fixed-latency operations into HI/LO and handles mthi/mtlo.
//               The result is computed at the accept edge and parked in
//               pending registers; a countdown models the latency and Busy
//               lets the hazard unit stall dependent instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]        r_hi, r_lo;
  logic [31:0]        w_hi_nxt, w_lo_nxt;
  logic [31:0]        r_pend_hi, r_pend_lo;
  logic [31:0]        w_pend_hi_nxt, w_pend_lo_nxt;

  logic [63:0]        w_a_sx, w_b_sx;
  logic [63:0]        w_prod_s, w_prod_u;
  logic               w_b_zero, w_div_ovf;
  logic signed [31:0] w_sq, w_sr;
  logic [31:0]        w_uq, w_ur;
  logic [31:0]        w_res_hi, w_res_lo;
  logic               w_is_mult;

  // Sign-extending both operands to 64 bits lets one unsigned multiply give
  // the exact signed 64-bit product.
  assign w_a_sx    = {{32{A[31]}}, A};
  assign w_b_sx    = {{32{B[31]}}, B};
  assign w_prod_s  = w_a_sx * w_b_sx;
  assign w_prod_u  = {32'd0, A} * {32'd0, B};
  assign w_b_zero  = (B == 32'd0);
  assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_is_mult = (MDOp == c_OP_MULT) || (MDOp == c_OP_MULTU);

  assign Busy  = (r_state == S_RUN);
  assign Start = (MDOp >= c_OP_MULT) && (MDOp <= c_OP_DIVU) && !Busy;
  assign HI    = r_hi;
  assign LO    = r_lo;

  // Guarded division: zero divisor and the one overflowing signed case are
  // resolved explicitly so no undefined quotient ever reaches the result mux.
  always_comb begin
    w_sq = '0;
    w_sr = '0;
    w_uq = '0;
    w_ur = '0;
    if (!w_b_zero) begin
      w_uq = A / B;
      w_ur = A % B;
      if (w_div_ovf) begin
        w_sq = 32'sh8000_0000;
        w_sr = 32'sd0;
      end else begin
        w_sq = $signed(A) / $signed(B);
        w_sr = $signed(A) % $signed(B);
      end
    end
  end

  // Result selection; a zero divisor reproduces the current HI/LO so the
  // completion write leaves them unchanged.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (MDOp)
      c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      c_OP_DIV: begin
        if (!w_b_zero) begin
          w_res_hi = w_sr;
          w_res_lo = w_sq;
        end
      end
      c_OP_DIVU: begin
        if (!w_b_zero) begin
          w_res_hi = w_ur;
          w_res_lo = w_uq;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic: accept ops or mthi/mtlo when idle, count down when running.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_pend_hi_nxt = w_res_hi;
          w_pend_lo_nxt = w_res_lo;
          w_cnt_nxt     = w_is_mult ? c_MULT_CNT : c_DIV_CNT;
          w_state_nxt   = S_RUN;
        end else if (MDOp == c_OP_MTHI) begin
          w_hi_nxt = A;
        end else if (MDOp == c_OP_MTLO) begin
          w_lo_nxt = A;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and data registers; reset clears everything and aborts any op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit: directed vector table,
//               hand-written stall/reset sequences and random ops compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start, Busy;
  logic [31:0] HI, LO;

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin pu = ua * ub; hi = pu[63:32]; lo = pu[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      3'd4: if (b != 0) begin pu = ua / ub; lo = pu[31:0]; pu = ua % ub; hi = pu[31:0]; end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op in an idle cycle, check latency and HI/LO hold, then result.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    bit md;
    int n;
    md = (op >= 3'd1) && (op <= 3'd4);
    n  = (op <= 3'd2) ? MC : DC;
    MDOp = op; A = a; B = b;
    #1;
    chk("start", {31'd0, Start}, {31'd0, md});
    if (md) begin
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        MDOp = 3'd0; A = $urandom; B = $urandom;
        chk("busy_run", {31'd0, Busy}, 32'd1);
        chk("hi_hold", HI, m_hi);
        chk("lo_hold", LO, m_lo);
      end
    end
    @(negedge clk);
    MDOp = 3'd0;
    chk("busy_done", {31'd0, Busy}, 32'd0);
    chk("hi_result", HI, ehi);
    chk("lo_result", LO, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;

    tbl[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'd4, 32'd7,         32'd2,          32'd1,         32'd3};
    tbl[4] = '{3'd6, 32'h0000_1234, 32'd0,          32'd1,         32'h0000_1234};
    tbl[5] = '{3'd3, 32'd5,         32'd0,          32'd1,         32'h0000_1234};
    tbl[6] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    tbl[7] = '{3'd5, 32'h0000_AAAA, 32'd0,          32'h0000_AAAA, 32'h8000_0000};

    reset = 1'b1; MDOp = 3'd0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_start", {31'd0, Start}, 32'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 8; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

    // Ops during Busy are ignored; a held mult is accepted when Busy drops
    MDOp = 3'd2; A = 32'd3; B = 32'd4;
    #1 chk("seq_start", {31'd0, Start}, 32'd1);
    @(negedge clk);
    MDOp = 3'd5; A = 32'h0000_AAAA;
    #1 chk("seq_mthi_busy", {31'd0, Start}, 32'd0);
    chk("seq_busy1", {31'd0, Busy}, 32'd1);
    @(negedge clk);
    MDOp = 3'd1; A = 32'hFFFF_FFFF; B = 32'd5;
    #1 chk("seq_mult_busy", {31'd0, Start}, 32'd0);
    repeat (MC - 2) @(negedge clk);
    chk("seq_busyN", {31'd0, Busy}, 32'd1);
    @(negedge clk);
    chk("seq_idle", {31'd0, Busy}, 32'd0);
    chk("seq_hi1", HI, 32'd0);
    chk("seq_lo1", LO, 32'd12);
    chk("seq_stall_accept", {31'd0, Start}, 32'd1);
    @(negedge clk);
    MDOp = 3'd0; A = $urandom; B = $urandom;
    chk("seq_busy2", {31'd0, Busy}, 32'd1);
    chk("seq_lo_hold", LO, 32'd12);
    repeat (MC - 1) @(negedge clk);
    chk("seq_busy2N", {31'd0, Busy}, 32'd1);
    @(negedge clk);
    chk("seq_idle2", {31'd0, Busy}, 32'd0);
    chk("seq_hi2", HI, 32'hFFFF_FFFF);
    chk("seq_lo2", LO, 32'hFFFF_FFFB);
    m_hi = HI === 32'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFB;

    // Asynchronous reset in the middle of a divide
    MDOp = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    MDOp = 3'd0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("arst_nowrite_busy", {31'd0, Busy}, 32'd0);
    chk("arst_nowrite_hi", HI, 32'd0);
    chk("arst_nowrite_lo", LO, 32'd0);
    m_hi = '0; m_lo = '0;

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3:    b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      eh = m_hi;
      el = m_lo;
      ref_md(op, a, b, eh, el);
      do_op(op, a, b, eh, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
